mem_port_arbiter: RTL and testbench

- Shares one 32-bit synchronous memory port between the core's instruction-fetch requester and its data requester.
- Sits between the core's inst/mem interfaces and a single unified memory with fixed read/write latency.
- Performs round-robin arbitration and word-alignment checks, sequences each access with a wait-state counter, and returns a one-cycle done pulse with registered read data.

---
 rtl/mem_port_arbiter.sv | 133 +++++++++++++
 tb/tb_mem_port_arbiter.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one fixed-latency synchronous memory port
// between the instruction-fetch and data requesters.
//
// state | meaning
// IDLE  | waiting for a request; grants one unless halted
// ISSUE | drives the one-cycle m_en strobe from the latched access
// WAIT  | counts down memory latency, captures read data at zero
// RESP  | pulses done/err to the granted requester
module mem_port_arbiter #(
  parameter int unsigned LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst_b,
  input  logic        halted,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic        i_done,
  output logic        i_err,
  output logic [31:0] i_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_done,
  output logic        d_err,
  output logic [31:0] d_rdata,
  output logic        m_en,
  output logic        m_we,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  input  logic [31:0] m_rdata,
  output logic        busy
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  logic [1:0]  state;
  logic [3:0]  cnt;
  logic        last_gnt;   // 1 = data was granted last
  logic        gnt_d;
  logic        lat_we;
  logic        lat_err;
  logic [31:2] lat_addr;
  logic [31:0] lat_wdata;

  logic        pick_d;
  logic [31:0] sel_addr;

  // Data wins only when fetch is not asking or fetch was served last.
  always_comb begin
    pick_d   = d_req & (~i_req | ~last_gnt);
    sel_addr = pick_d ? d_addr : i_addr;
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state     <= S_IDLE;
      cnt       <= 4'd0;
      last_gnt  <= 1'b1;
      gnt_d     <= 1'b0;
      lat_we    <= 1'b0;
      lat_err   <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      i_done    <= 1'b0;
      i_err     <= 1'b0;
      i_rdata   <= '0;
      d_done    <= 1'b0;
      d_err     <= 1'b0;
      d_rdata   <= '0;
      m_en      <= 1'b0;
      m_we      <= 1'b0;
      m_addr    <= '0;
      m_wdata   <= '0;
      busy      <= 1'b0;
    end else begin
      m_en   <= 1'b0;
      i_done <= 1'b0;
      i_err  <= 1'b0;
      d_done <= 1'b0;
      d_err  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (!halted && (i_req || d_req)) begin
            gnt_d     <= pick_d;
            last_gnt  <= pick_d;
            lat_addr  <= sel_addr[31:2];
            lat_we    <= pick_d & d_we;
            lat_wdata <= pick_d ? d_wdata : 32'd0;
            lat_err   <= |sel_addr[1:0];
            state     <= (|sel_addr[1:0]) ? S_RESP : S_ISSUE;
            busy      <= 1'b1;
          end
        end
        S_ISSUE: begin
          m_en    <= 1'b1;
          m_we    <= lat_we;
          m_addr  <= {lat_addr, 2'b00};
          m_wdata <= lat_wdata;
          cnt     <= 4'(LATENCY - 1);
          state   <= S_WAIT;
        end
        S_WAIT: begin
          if (cnt == 4'd0) begin
            // Store responses leave d_rdata untouched.
            if (!gnt_d)
              i_rdata <= m_rdata;
            else if (!lat_we)
              d_rdata <= m_rdata;
            state <= S_RESP;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        default: begin
          if (gnt_d) begin
            d_done <= 1'b1;
            d_err  <= lat_err;
          end else begin
            i_done <= 1'b1;
            i_err  <= lat_err;
          end
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized and directed bench for mem_port_arbiter against a
// transaction-level model of grant order, completion time and memory contents.
module tb_mem_port_arbiter;
  localparam int L = 2;

  logic        clk = 1'b0;
  logic        rst_b, halted;
  logic        i_req, d_req, d_we;
  logic [31:0] i_addr, d_addr, d_wdata;
  logic        i_done, i_err, d_done, d_err;
  logic [31:0] i_rdata, d_rdata;
  logic        m_en, m_we, busy;
  logic [31:0] m_addr, m_wdata, m_rdata;

  mem_port_arbiter #(.LATENCY(L)) dut (
    .clk(clk), .rst_b(rst_b), .halted(halted),
    .i_req(i_req), .i_addr(i_addr), .i_done(i_done), .i_err(i_err), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_done(d_done), .d_err(d_err), .d_rdata(d_rdata),
    .m_en(m_en), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_rdata(m_rdata),
    .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_init(input logic [7:0] idx);
    if (idx == 8'h10) return 32'h12345678;
    return ({24'h0, idx} * 32'h9E3779B1) ^ 32'h5A5A0000;
  endfunction

  // Memory seen by the DUT: written on m_en & m_we, read data held from m_addr.
  bit [31:0] mem [256];
  bit        wr  [256];
  always @(posedge clk)
    if (m_en && m_we) begin
      mem[m_addr[9:2]] <= m_wdata;
      wr[m_addr[9:2]]  <= 1'b1;
    end
  assign m_rdata = wr[m_addr[9:2]] ? mem[m_addr[9:2]] : mem_init(m_addr[9:2]);

  // Reference model state.
  logic [31:0] ref_mem [256];
  bit          m_last_d;
  logic [31:0] exp_i_rdata, exp_d_rdata;
  int          n_checks = 0, n_pass = 0;

  typedef struct { logic [31:0] addr; bit we; logic [31:0] wdata; } men_t;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %08h expected %08h", tag, got, exp);
  endtask

  task automatic model_reset();
    m_last_d    = 1'b1;
    exp_i_rdata = '0;
    exp_d_rdata = '0;
  endtask

  task automatic do_reset();
    rst_b = 1'b0; halted = 1'b0; i_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
    i_addr = '0; d_addr = '0; d_wdata = '0;
    repeat (2) @(negedge clk);
    rst_b = 1'b1;
    model_reset();
  endtask

  task automatic check_idle_outputs(input string tag);
    check_eq({tag, "_ctl"}, 32'({i_done, i_err, d_done, d_err, m_en, m_we, busy}), 32'd0);
    check_eq({tag, "_i_rdata"}, i_rdata, 32'd0);
    check_eq({tag, "_d_rdata"}, d_rdata, 32'd0);
    check_eq({tag, "_m_addr"}, m_addr, 32'd0);
    check_eq({tag, "_m_wdata"}, m_wdata, 32'd0);
  endtask

  function automatic int svc(input logic [31:0] a);
    return (a[1:0] != 2'b00) ? 1 : L + 2;
  endfunction

  // One or two simultaneous requests; each requester drops req in its done cycle.
  task automatic run_acc(input bit i_on, input logic [31:0] ia, input bit d_on,
                         input bit dwe, input logic [31:0] da, input logic [31:0] dwd);
    bit   first_d;
    int   exp_ki, exp_kd, ki, kd, n_men, exp_men;
    men_t q[$];
    men_t e;
    men_t ei, ed;
    first_d = (i_on && d_on) ? !m_last_d : d_on;
    exp_ki = -1; exp_kd = -1; ki = -1; kd = -1; n_men = 0;
    ei = '{addr: {ia[31:2], 2'b00}, we: 1'b0, wdata: 32'd0};
    ed = '{addr: {da[31:2], 2'b00}, we: dwe, wdata: dwd};
    if (first_d) begin
      exp_kd = 1 + svc(da);
      if (da[1:0] == 2'b00) q.push_back(ed);
      if (i_on) begin
        exp_ki = exp_kd + 1 + svc(ia);
        if (ia[1:0] == 2'b00) q.push_back(ei);
      end
    end else begin
      exp_ki = 1 + svc(ia);
      if (ia[1:0] == 2'b00) q.push_back(ei);
      if (d_on) begin
        exp_kd = exp_ki + 1 + svc(da);
        if (da[1:0] == 2'b00) q.push_back(ed);
      end
    end
    exp_men = q.size();
    m_last_d = (i_on && d_on) ? !first_d : d_on;

    @(negedge clk);
    i_req = i_on; i_addr = ia;
    d_req = d_on; d_we = dwe; d_addr = da; d_wdata = dwd;
    for (int k = 1; k <= 60; k++) begin
      @(posedge clk); #1;
      if (m_en) begin
        n_men++;
        if (q.size() != 0) begin
          e = q.pop_front();
          check_eq("m_addr", m_addr, e.addr);
          check_eq("m_we", 32'(m_we), 32'(e.we));
          if (e.we) check_eq("m_wdata", m_wdata, e.wdata);
        end
      end
      if (i_done && i_on && ki < 0) begin
        ki = k; i_req = 1'b0;
        check_eq("i_err", 32'(i_err), 32'(ia[1:0] != 2'b00));
        if (ia[1:0] == 2'b00) exp_i_rdata = ref_mem[ia[9:2]];
        check_eq("i_rdata", i_rdata, exp_i_rdata);
      end
      if (d_done && d_on && kd < 0) begin
        kd = k; d_req = 1'b0;
        check_eq("d_err", 32'(d_err), 32'(da[1:0] != 2'b00));
        if (da[1:0] == 2'b00) begin
          if (dwe) ref_mem[da[9:2]] = dwd;
          else     exp_d_rdata = ref_mem[da[9:2]];
        end
        check_eq("d_rdata", d_rdata, exp_d_rdata);
      end
      if ((!i_on || ki >= 0) && (!d_on || kd >= 0)) break;
    end
    if (i_on) check_eq("i_done_cycle", ki, exp_ki);
    if (d_on) check_eq("d_done_cycle", kd, exp_kd);
    check_eq("m_en_count", n_men, exp_men);
    @(posedge clk); #1;
    check_eq("done_clear", 32'({i_done, i_err, d_done, d_err}), 32'd0);
  endtask

  initial begin
    int nd, last_k, kk, cnt;
    bit exp_d;
    for (int i = 0; i < 256; i++) ref_mem[i] = mem_init(8'(i));
    do_reset();
    #1;
    check_idle_outputs("reset");

    // Single fetch, then store/load round trip.
    run_acc(1'b1, 32'h40, 1'b0, 1'b0, 32'h0, 32'h0);
    check_eq("fetch_0x40", i_rdata, 32'h12345678);
    run_acc(1'b0, 32'h0, 1'b1, 1'b1, 32'h100, 32'hDEADBEEF);
    run_acc(1'b0, 32'h0, 1'b1, 1'b0, 32'h100, 32'h0);
    check_eq("load_0x100", d_rdata, 32'hDEADBEEF);

    // Misaligned data access, then an aligned one.
    run_acc(1'b0, 32'h0, 1'b1, 1'b0, 32'h102, 32'h0);
    run_acc(1'b0, 32'h0, 1'b1, 1'b0, 32'h104, 32'h0);

    // Both requests held continuously: strict alternation starting with fetch.
    do_reset();
    @(negedge clk);
    i_req = 1'b1; i_addr = 32'h200; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h300;
    nd = 0; last_k = -1; exp_d = 1'b0;
    for (int k = 1; k <= 200; k++) begin
      @(posedge clk); #1;
      if (i_done || d_done) begin
        check_eq("rr_both", 32'(i_done & d_done), 32'd0);
        check_eq("rr_who", 32'(d_done), 32'(exp_d));
        check_eq("rr_gap", (last_k < 0) ? k : k - last_k, (last_k < 0) ? L + 3 : L + 3);
        if (d_done) check_eq("rr_d_rdata", d_rdata, ref_mem[8'hC0]);
        else        check_eq("rr_i_rdata", i_rdata, ref_mem[8'h80]);
        last_k = k; exp_d = !exp_d; nd++;
        if (nd == 6) begin
          i_req = 1'b0; d_req = 1'b0;
          break;
        end
      end
    end
    check_eq("rr_count", nd, 6);
    m_last_d = 1'b1;
    exp_i_rdata = ref_mem[8'h80];
    exp_d_rdata = ref_mem[8'hC0];

    // Reset while in WAIT abandons the access.
    @(negedge clk);
    i_req = 1'b1; i_addr = 32'h44;
    repeat (3) @(posedge clk);
    #1;
    check_eq("wait_busy", 32'(busy), 32'd1);
    rst_b = 1'b0;
    #1;
    check_idle_outputs("rst_mid");
    i_req = 1'b0;
    @(negedge clk);
    rst_b = 1'b1;
    model_reset();
    cnt = 0;
    repeat (10) begin
      @(posedge clk); #1;
      cnt += int'(i_done) + int'(d_done) + int'(m_en);
    end
    check_eq("rst_no_done", cnt, 0);
    run_acc(1'b1, 32'h48, 1'b1, 1'b0, 32'h4C, 32'h0);

    // halted raised during ISSUE: access completes, then no grants.
    @(negedge clk);
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h80;
    @(posedge clk); #1;
    halted = 1'b1;
    kk = -1;
    for (int k = 2; k <= 40; k++) begin
      @(posedge clk); #1;
      if (d_done) begin kk = k; break; end
    end
    check_eq("halt_done_cycle", kk, L + 3);
    exp_d_rdata = ref_mem[8'h20];
    check_eq("halt_d_rdata", d_rdata, exp_d_rdata);
    d_req = 1'b0;
    m_last_d = 1'b1;
    @(negedge clk);
    i_req = 1'b1; i_addr = 32'h84;
    cnt = 0;
    repeat (20) begin
      @(posedge clk); #1;
      cnt += int'(m_en) + int'(i_done) + int'(busy);
    end
    check_eq("halt_no_grant", cnt, 0);
    @(negedge clk);
    halted = 1'b0;
    kk = -1;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (i_done) begin kk = k; break; end
    end
    check_eq("unhalt_done_cycle", kk, L + 3);
    exp_i_rdata = ref_mem[8'h21];
    check_eq("unhalt_i_rdata", i_rdata, exp_i_rdata);
    i_req = 1'b0;
    m_last_d = 1'b0;

    // Randomized single and contending accesses.
    for (int n = 0; n < 40; n++) begin
      bit io, dn, we;
      logic [31:0] ia, da;
      io = 1'($urandom_range(0, 1));
      dn = 1'($urandom_range(0, 1));
      if (!io && !dn) io = 1'b1;
      we = 1'($urandom_range(0, 1));
      ia = {22'd0, 8'($urandom), ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'b00};
      da = {22'd0, 8'($urandom), ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'b00};
      repeat ($urandom_range(0, 3)) @(negedge clk);
      run_acc(io, ia, dn, we, da, $urandom);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
